// File: rtl/noc_output_arbiter_if.sv
// Handshake/bus bundle between an output-port arbiter, its input FIFO read
// side and the downstream hop.
interface noc_output_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] fifo_data;
  logic                     ro;
  logic [NUM_REQ-1:0]       rd_en;
  logic                     so;
  logic [WIDTH-1:0]         out_packet;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [15:0]              sent_count;

  // Arbiter side
  modport master (
    input  req, fifo_data, ro,
    output rd_en, so, out_packet, grant, busy, sent_count
  );

  // FIFO / downstream side
  modport slave (
    output req, fifo_data, ro,
    input  rd_en, so, out_packet, grant, busy, sent_count
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin arbiter for one router output port: pops one packet from the
// winning input FIFO, registers it and holds it on so/ro until accepted.
module noc_output_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_output_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   rd_en_q, rd_en_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 so_q, so_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     pkt_q, pkt_d;
  logic [CNT_W-1:0]     sent_count_q, sent_count_d;

  logic                 winner_vld_c;
  logic [IDX_W-1:0]     winner_idx_c;
  logic [IDX_W-1:0]     grant_idx_c;

  // First set req bit at or above rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    winner_vld_c = 1'b0;
    winner_idx_c = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[rr_ptr_q + IDX_W'(k)]) begin
        winner_vld_c = 1'b1;
        winner_idx_c = rr_ptr_q + IDX_W'(k);
      end
    end
  end

  always_comb begin
    grant_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) grant_idx_c = IDX_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rd_en_d      = '0;
    rr_ptr_d     = rr_ptr_q;
    pkt_d        = pkt_q;
    sent_count_d = sent_count_q;
    so_d         = 1'b0;
    busy_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (winner_vld_c) begin
          state_d = READ;
          grant_d = NUM_REQ'(1) << winner_idx_c;
          rd_en_d = NUM_REQ'(1) << winner_idx_c;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        pkt_d   = bus.fifo_data[grant_idx_c*WIDTH +: WIDTH];
        state_d = SEND;
      end
      SEND: begin
        if (bus.ro) begin
          state_d      = IDLE;
          grant_d      = '0;
          rr_ptr_d     = grant_idx_c + IDX_W'(1);
          sent_count_d = sent_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // so/busy registered from the next state so they track the FSM exactly
    so_d   = (state_d == SEND);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rd_en_q      <= '0;
      rr_ptr_q     <= '0;
      pkt_q        <= '0;
      sent_count_q <= '0;
      so_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rd_en_q      <= rd_en_d;
      rr_ptr_q     <= rr_ptr_d;
      pkt_q        <= pkt_d;
      sent_count_q <= sent_count_d;
      so_q         <= so_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.so         = so_q;
  assign bus.out_packet = pkt_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.sent_count = sent_count_q;

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Round-robin arbiter and sequencer for one router output port. It shares the port among `NUM_REQ` input FIFOs, each of which is loaded by an input handshake stage. It pops one packet from the winning FIFO, holds it in an output register, and presents it downstream on the si/ri-style valid/ready handshake (`so`/`ro`) until accepted. One instance sits per output port, between the input FIFO read side and the next hop's input handshake stage.

## Interface
- `NUM_REQ`, 4: number of requesting input FIFOs; must be ≥2 and a power of two.
- `WIDTH`, 64: packet width in bits.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; low clears all state immediately.
- `req`  in  NUM_REQ  bit i high = FIFO i is non-empty and its head packet is routed to this port.
- `fifo_data`  in  NUM_REQ*WIDTH  FIFO read data; slice i = bits [i*WIDTH +: WIDTH].
- `ro`  in  1  downstream ready (next hop's `ri`).
- `rd_en`  out  NUM_REQ  one-hot FIFO pop strobe, one cycle.
- `so`  out  1  downstream valid (next hop's `si`).
- `out_packet`  out  WIDTH  packet presented downstream.
- `grant`  out  NUM_REQ  one-hot owner of the port; all-zero when idle.
- `busy`  out  1  high in every state except IDLE.
- `sent_count`  out  16  packets delivered; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, READ, LOAD, SEND. Reset state is IDLE.
- Reset values: `rd_en`=0, `so`=0, `out_packet`=0, `grant`=0, `busy`=0, `sent_count`=0, `rr_ptr`=0.
- IDLE:
  - `req` is sampled only in this state.
  - If any `req` bit is set, the winner is the first set bit searching upward from `rr_ptr`, modulo NUM_REQ.
  - Next state is READ, with `grant` registered as the winner's one-hot.
  - If no `req` bit is set, stay in IDLE.
- READ: `rd_en` = `grant` for exactly this cycle. Next state is LOAD.
- LOAD:
  - FIFO read data is valid one cycle after `rd_en`.
  - `out_packet` ← `fifo_data` slice selected by `grant`. Next state is SEND.
- SEND:
  - `so`=1 and `out_packet` is held stable.
  - Transfer occurs on a cycle with `so`&&`ro`.
  - On transfer: `rr_ptr` ← (grant index + 1) mod NUM_REQ, `sent_count` += 1, `grant` ← 0, next state is IDLE.
  - If `ro`=0, stay in SEND indefinitely. This is backpressure; there is no timeout.
- `so` and `rd_en` are decoded from registered state only, with no combinational path from `ro` or `req`.
- `req` changes during READ/LOAD/SEND are ignored. A requester must hold `req` until it sees its `rd_en`. A requester whose FIFO still holds packets may re-win only after the others, per round-robin order.
- Reset low in any state: return to IDLE with the reset values above. Any in-flight packet is dropped, and no `rd_en` is issued during or after the assertion.

## Timing
- `req` high in IDLE at edge 0 → READ after edge 0 (`rd_en` high in cycle 1).
- LOAD in cycle 2.
- `so` high from cycle 3.
- Earliest acceptance is at edge 4. Back in IDLE in cycle 4.
- Maximum throughput is one packet per 4 cycles.
- `sent_count` and `rr_ptr` update on the same edge as the transfer.
- Simultaneous requests resolve in one cycle; there is no multi-cycle arbitration.

## Test plan
- Single requester: `req`=4'b0100, `ro`=1 → `rd_en`=4'b0100 in cycle 1; `so`=1 in cycle 3 with `out_packet` = slice 2; `sent_count`=1; `rr_ptr`=3.
- Fairness: `req`=4'b1111 held, `ro`=1, 8 packets → grant order 0,1,2,3,0,1,2,3; exactly one `rd_en` pulse per grant; `sent_count`=8.
- Wrap: `rr_ptr`=3, `req`=4'b1001 → grant 3 first, then 0; `rr_ptr` ends at 1.
- Backpressure: `ro`=0 for 5 cycles in SEND → `so` stays 1, `out_packet` is unchanged, no further `rd_en`; `ro`=1 → single transfer, IDLE next cycle.
- Reset mid-SEND: assert `reset`=0 while `so`=1 → `so`, `grant`, `busy`, `sent_count` go to 0 without waiting for a clock edge; after release with `req`=0, the block stays idle.
- Counter wrap: preload by 65535 transfers (or force) → next transfer gives `sent_count`=0.
